// File: rtl/add_szer_if.sv
// -----------------------------------------------------------------------------
// add_szer_if
// Handshake and operand/result bundle for the bit-serial adder.
//   START  : request strobe, sampled by the adder only while it is idle
//   A, B   : N-bit operands, captured with an accepted START
//   C_wej  : carry-in, captured with an accepted START
//   BUSY   : high while a serial addition is in progress
//   GOTOWE : one-cycle completion pulse, Q/C_wyj were just updated
//   Q      : N-bit registered sum, held until the next completion
//   C_wyj  : registered carry-out, held with Q
// master = requester side, slave = adder side.
// -----------------------------------------------------------------------------
interface add_szer_if #(
    parameter int N = 8
);
    logic         START;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         C_wej;
    logic         BUSY;
    logic         GOTOWE;
    logic [N-1:0] Q;
    logic         C_wyj;

    modport master (
        output START, A, B, C_wej,
        input  BUSY, GOTOWE, Q, C_wyj
    );

    modport slave (
        input  START, A, B, C_wej,
        output BUSY, GOTOWE, Q, C_wyj
    );
endinterface

// File: rtl/add_szer.sv
// -----------------------------------------------------------------------------
// add_szer
// Bit-serial N-bit adder with carry-in. An accepted START latches A, B and
// C_wej; one bit per clock (LSB first) then passes through a single full-adder
// cell with a carry flip-flop. After N clocks {C_wyj, Q} = A + B + C_wej is
// published together with a one-cycle GOTOWE pulse.
// Ports:
//   CLK    : rising-edge clock
//   RST_N  : asynchronous active-low reset, clears all state
//   bus    : add_szer_if.slave (START, A, B, C_wej in; BUSY, GOTOWE, Q, C_wyj out)
// -----------------------------------------------------------------------------
module add_szer #(
    parameter int N = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    add_szer_if.slave   bus
);
    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  ra_q, ra_d;
    logic [N-1:0]  rb_q, rb_d;
    logic [N-1:0]  rq_q, rq_d;
    logic [N-1:0]  q_q, q_d;
    logic          c_q, c_d;
    logic          cwyj_q, cwyj_d;
    logic          gotowe_q, gotowe_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          s;
    logic          cout;
    logic [N:0]    rq_sh;
    logic          unused_rq_lsb;

    function automatic logic fa_sum(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic ci);
        return (a & b) | (ci & (a ^ b));
    endfunction

    // New sum bit enters at the MSB; the bit shifted out of rq is dropped.
    assign rq_sh         = {s, rq_q};
    assign unused_rq_lsb = rq_sh[0];

    always_comb begin
        s        = fa_sum(ra_q[0], rb_q[0], c_q);
        cout     = fa_carry(ra_q[0], rb_q[0], c_q);
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rq_d     = rq_q;
        q_d      = q_q;
        c_d      = c_q;
        cwyj_d   = cwyj_q;
        cnt_d    = cnt_q;
        gotowe_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    ra_d    = bus.A;
                    rb_d    = bus.B;
                    c_d     = bus.C_wej;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                c_d   = cout;
                rq_d  = rq_sh[N:1];
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the whole word at once so Q never
                // exposes a partial sum.
                if (cnt_q == LAST) begin
                    q_d      = rq_sh[N:1];
                    cwyj_d   = cout;
                    gotowe_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            rq_q     <= '0;
            q_q      <= '0;
            c_q      <= 1'b0;
            cwyj_q   <= 1'b0;
            gotowe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rq_q     <= rq_d;
            q_q      <= q_d;
            c_q      <= c_d;
            cwyj_q   <= cwyj_d;
            gotowe_q <= gotowe_d;
            cnt_q    <= cnt_d;
        end
    end

    // BUSY is decoded straight from the state register, so it is glitch-free
    // and has no path from the inputs.
    assign bus.BUSY   = (state_q == SHIFT);
    assign bus.GOTOWE = gotowe_q;
    assign bus.Q      = q_q;
    assign bus.C_wyj  = cwyj_q;

endmodule

// File: tb/tb_add_szer.sv
// -----------------------------------------------------------------------------
// tb_add_szer
// Scoreboard bench for add_szer at N=1, N=8 and N=32. Stimulus pushes the
// expected {C_wyj, Q} when a START is accepted; per-instance monitors pop and
// compare on every GOTOWE pulse.
// -----------------------------------------------------------------------------
module tb_add_szer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_szer_if #(.N(1))  b1();
    add_szer_if #(.N(8))  b8();
    add_szer_if #(.N(32)) b32();

    add_szer #(.N(1))  u1  (.CLK(clk), .RST_N(rst_n), .bus(b1));
    add_szer #(.N(8))  u8  (.CLK(clk), .RST_N(rst_n), .bus(b8));
    add_szer #(.N(32)) u32 (.CLK(clk), .RST_N(rst_n), .bus(b32));

    int n_cmp  = 0;
    int n_fail = 0;
    int g8_cnt = 0;

    logic [1:0]  q1  [$];
    logic [8:0]  q8  [$];
    logic [32:0] q32 [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: GOTOWE with empty scoreboard", name);
    endtask

    // Monitors: sample 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && b8.GOTOWE) begin
            g8_cnt++;
            if (q8.size() == 0) unexpected("n8_gotowe");
            else chk("n8_result", 64'({b8.C_wyj, b8.Q}), 64'(q8.pop_front()));
        end
        if (rst_n && b1.GOTOWE) begin
            if (q1.size() == 0) unexpected("n1_gotowe");
            else chk("n1_result", 64'({b1.C_wyj, b1.Q}), 64'(q1.pop_front()));
        end
        if (rst_n && b32.GOTOWE) begin
            if (q32.size() == 0) unexpected("n32_gotowe");
            else chk("n32_result", 64'({b32.C_wyj, b32.Q}), 64'(q32.pop_front()));
        end
    end

    // Counts posedges (starting with the accepting edge) until GOTOWE is seen.
    task automatic wait_gotowe8(input string name, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (b8.GOTOWE) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no GOTOWE within 40 cycles", name);
        end
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [8:0] exp);
        @(negedge clk);
        b8.A = a;
        b8.B = b;
        b8.C_wej = c;
        b8.START = 1'b1;
        q8.push_back(exp);
    endtask

    int cyc;
    int bc;
    int gsave;

    initial begin
        b1.START = 0;  b1.A = '0;  b1.B = '0;  b1.C_wej = 0;
        b8.START = 0;  b8.A = '0;  b8.B = '0;  b8.C_wej = 0;
        b32.START = 0; b32.A = '0; b32.B = '0; b32.C_wej = 0;

        // Reset state
        #12;
        chk("rst_busy",   64'(b8.BUSY),   64'd0);
        chk("rst_gotowe", 64'(b8.GOTOWE), 64'd0);
        chk("rst_q",      64'(b8.Q),      64'd0);
        chk("rst_cwyj",   64'(b8.C_wyj),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: 20 cycles, no GOTOWE, Q stays 0
        repeat (20) @(negedge clk);
        chk("idle_gotowe_count", 64'(g8_cnt), 64'd0);
        chk("idle_q",            64'(b8.Q),   64'd0);
        chk("idle_busy",         64'(b8.BUSY), 64'd0);

        // Overflow: FF + 01 + 0 = 1_00; BUSY high for exactly 8 cycles
        start8(8'hFF, 8'h01, 1'b0, 9'h100);
        @(posedge clk);
        #1;
        b8.START = 1'b0;
        bc = 0;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            if (b8.BUSY) bc++;
            @(posedge clk);
            #1;
            if (b8.GOTOWE && cyc == 0) cyc = i + 1;
        end
        chk("ovf_busy_cycles", 64'(bc), 64'd8);
        chk("ovf_latency",     64'(cyc), 64'd8);
        chk("ovf_q_held",      64'({b8.C_wyj, b8.Q}), 64'h100);

        // Carry-in cases
        start8(8'h5A, 8'h3C, 1'b1, 9'h097);
        @(negedge clk) b8.START = 1'b0;
        wait_gotowe8("cin1_done", cyc);
        start8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        @(negedge clk) b8.START = 1'b0;
        wait_gotowe8("cin2_done", cyc);

        // START while busy is ignored
        gsave = g8_cnt;
        start8(8'h10, 8'h20, 1'b0, 9'h030);
        @(negedge clk) b8.START = 1'b0;
        repeat (2) @(negedge clk);
        b8.A = 8'hAA;
        b8.B = 8'hAA;
        b8.START = 1'b1;
        @(negedge clk) b8.START = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy_start_one_gotowe", 64'(g8_cnt - gsave), 64'd1);

        // Back-to-back: START held high, second operands shown in GOTOWE cycle
        start8(8'h01, 8'h02, 1'b0, 9'h003);
        wait_gotowe8("b2b_first", cyc);
        chk("b2b_first_latency", 64'(cyc), 64'd9);
        b8.A = 8'h80;
        b8.B = 8'h80;
        q8.push_back(9'h100);
        cyc = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk);
            #1;
            if (j == 1) b8.START = 1'b0;
            if (b8.GOTOWE) begin
                cyc = j;
                break;
            end
        end
        chk("b2b_second_latency", 64'(cyc), 64'd9);

        // Reset in the middle of an operation
        gsave = g8_cnt;
        start8(8'h33, 8'h11, 1'b0, 9'h044);
        @(negedge clk) b8.START = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q8.delete();
        chk("mid_rst_busy", 64'(b8.BUSY),  64'd0);
        chk("mid_rst_q",    64'(b8.Q),     64'd0);
        chk("mid_rst_cwyj", 64'(b8.C_wyj), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_gotowe", 64'(g8_cnt - gsave), 64'd0);
        start8(8'h0F, 8'h01, 1'b0, 9'h010);
        @(negedge clk) b8.START = 1'b0;
        wait_gotowe8("post_rst_done", cyc);

        // Random sweeps, three widths in parallel
        fork
            begin
                logic [0:0] a, b;
                logic       c;
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
                    b1.A = a; b1.B = b; b1.C_wej = c; b1.START = 1'b1;
                    q1.push_back(2'(a) + 2'(b) + 2'(c));
                    @(negedge clk) b1.START = 1'b0;
                    repeat (1) @(negedge clk);
                end
            end
            begin
                logic [7:0] a, b;
                logic       c;
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
                    b8.A = a; b8.B = b; b8.C_wej = c; b8.START = 1'b1;
                    q8.push_back(9'(a) + 9'(b) + 9'(c));
                    @(negedge clk) b8.START = 1'b0;
                    repeat (8) @(negedge clk);
                end
            end
            begin
                logic [31:0] a, b;
                logic        c;
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    a = $urandom; b = $urandom; c = 1'($urandom);
                    b32.A = a; b32.B = b; b32.C_wej = c; b32.START = 1'b1;
                    q32.push_back(33'(a) + 33'(b) + 33'(c));
                    @(negedge clk) b32.START = 1'b0;
                    repeat (32) @(negedge clk);
                end
            end
        join

        // Drain: every pushed expectation must have been consumed
        for (int i = 0; i < 100; i++) begin
            if (q1.size() == 0 && q8.size() == 0 && q32.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_q1",  64'(q1.size()),  64'd0);
        chk("drain_q8",  64'(q8.size()),  64'd0);
        chk("drain_q32", 64'(q32.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/add_szer.md
# add_szer

Bit-serial N-bit adder with carry-in: the addition counterpart of the one-bit full subtractor cell in the arithmetic library. It latches two operands and a carry-in on a start strobe, then processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It presents the N-bit sum and the carry-out with a one-cycle completion pulse. It sits beside the serial subtract path in the datapath and shares its start/busy/done handshake.

## Interface
- N, default 8, operand and result width; legal range 1..32.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous reset, active low.
- START  in  1  request strobe; sampled only in IDLE.
- A  in  N  first operand, sampled when START is accepted.
- B  in  N  second operand, sampled when START is accepted.
- C_wej  in  1  carry-in, sampled when START is accepted.
- BUSY  out  1  high while a bit-serial addition is in progress.
- GOTOWE  out  1  one-cycle pulse marking that Q and C_wyj were just updated.
- Q  out  N  sum, registered, held until the next completion.
- C_wyj  out  1  carry-out, registered, held with Q.

## Operation
- Result: {C_wyj, Q} = A + B + C_wej, exact, no truncation.
- Internal state:
  - Two N-bit shift registers, ra and rb.
  - N-bit result shift register rq.
  - Carry flip-flop c.
  - Bit counter cnt, width clog2(N+1).
  - State register: IDLE or SHIFT.
- IDLE to SHIFT, when START=1 at an edge:
  - ra<=A, rb<=B, c<=C_wej, cnt<=0, BUSY<=1.
- SHIFT, at each edge:
  - s = ra[0]^rb[0]^c.
  - c <= (ra[0]&rb[0]) | (c&(ra[0]^rb[0])).
  - ra and rb shift right by one.
  - rq <= {s, rq[N-1:1]}.
  - cnt <= cnt+1.
- SHIFT to IDLE, at the edge where cnt == N-1 (the last bit):
  - Q <= {s, rq[N-1:1]}.
  - C_wyj <= final carry.
  - GOTOWE <= 1 for exactly one cycle.
  - BUSY <= 0.
- START while BUSY=1 is ignored: operands are not resampled and the operation is not restarted.
- START in the cycle where GOTOWE=1 is accepted, because the state is already IDLE. Back-to-back operations are legal.
- Q and C_wyj change only at a completion edge. They never show partial sums.
- Reset, including in the middle of an operation:
  - State goes to IDLE immediately.
  - BUSY=0, GOTOWE=0, Q=0, C_wyj=0.
  - ra, rb, rq, c and cnt clear to 0.
  - The operation in flight is discarded and produces no GOTOWE.

## Timing
- Reset values: BUSY=0, GOTOWE=0, Q=0, C_wyj=0.
- START is sampled at edge k:
  - BUSY is high from after edge k until edge k+N.
  - Q, C_wyj and GOTOWE=1 are valid after edge k+N.
  - GOTOWE clears at edge k+N+1 unless a new operation completes there. That is impossible for N≥1.
- Latency is N clocks from the accepting edge to the result.
- Minimum period between accepted STARTs is N+1 clocks.
- N=1 boundary: the operation completes at the first SHIFT edge, so BUSY is high for one cycle.
- Operand and C_wej inputs are don't-care except in the accepting cycle.
- Carry flip-flop: c holds the carry into bit i during SHIFT cycle i. No combinational path from inputs to outputs.

## Test plan
- Reset then idle, N=8: outputs are 0 and BUSY=0. 20 cycles with START=0 produce no GOTOWE and Q stays 0x00.
- Overflow, N=8: A=0xFF, B=0x01, C_wej=0, START for one cycle. Eight cycles later GOTOWE=1, Q=0x00, C_wyj=1, and BUSY was high for exactly 8 cycles.
- Carry-in, N=8: A=0x5A, B=0x3C, C_wej=1 gives Q=0x97, C_wyj=0. A=0xFF, B=0xFF, C_wej=1 gives Q=0xFF, C_wyj=1.
- START while busy, N=8: start A=0x10, B=0x20. Pulse START with A=0xAA, B=0xAA at cycle 3. The result is Q=0x30, C_wyj=0, and only one GOTOWE occurs.
- Back-to-back, N=8: START held high with A=0x01, B=0x02, then A=0x80, B=0x80 presented in the GOTOWE cycle. Q=0x03 after 8 clocks, then Q=0x00 with C_wyj=1 after 9 more clocks.
- Reset mid-operation, N=8: assert RST_N=0 at cycle 4 of an addition. Outputs clear immediately and no GOTOWE occurs. After release, a fresh START with A=0x0F, B=0x01 returns Q=0x10.
- Random sweep: N=1, N=8 and N=32 with 1000 random operands each, compared against {C_wyj,Q} = A+B+C_wej.
